// File: rtl/vga_controller.sv
// 640x480@60 Hz raster timing generator: pixel-enable divider, x/y counters and
// sync/blanking flags decoded from the next raster position so all outputs move together.
module vga_controller #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  // 11-bit bounds so an edge that lands exactly on 1024 still compares correctly
  localparam logic [10:0] H_VIS_END  = 11'(H_DISPLAY);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_DISPLAY);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [9:0]  X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 2) begin : g_param_check
    $error("vga_controller: H_TOTAL/V_TOTAL must be <= 1024 and CLK_DIV >= 2");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             adv, x_wrap, y_wrap;
  logic             p_tick_q, line_tick_q, frame_tick_q;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;

  always_comb begin
    adv    = (div_q == DIV_LAST);
    div_d  = adv ? '0 : div_q + DIV_W'(1);
    x_wrap = (x_q == X_LAST);
    y_wrap = (y_q == Y_LAST);
    x_d    = x_q;
    y_d    = y_q;
    if (adv) begin
      if (x_wrap) begin
        x_d = '0;
        y_d = y_wrap ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    video_on_d = ({1'b0, x_d} < H_VIS_END) && ({1'b0, y_d} < V_VIS_END);
    hsync_d    = (({1'b0, x_d} >= H_SYNC_BEG) && ({1'b0, x_d} < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d    = (({1'b0, y_d} >= V_SYNC_BEG) && ({1'b0, y_d} < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      p_tick_q     <= 1'b0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      video_on_q   <= 1'b0;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
    end else begin
      div_q        <= div_d;
      x_q          <= x_d;
      y_q          <= y_d;
      p_tick_q     <= adv;
      line_tick_q  <= adv && x_wrap;
      frame_tick_q <= adv && x_wrap && y_wrap;
      video_on_q   <= video_on_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
    end
  end

  assign p_tick     = p_tick_q;
  assign x          = x_q;
  assign y          = y_q;
  assign video_on   = video_on_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_controller.sv
// Scoreboarded bench for vga_controller on a shrunken raster; the reference derives every
// output from the number of clocks since reset release using plain division/modulo.
module tb_vga_controller;
  localparam int DIV = 4;
  localparam int HD = 20, HF = 4, HS = 6, HB = 5;
  localparam int VD = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME = DIV * HT * VT;
  localparam bit POL = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       p_tick, video_on, hsync, vsync, line_tick, frame_tick;
  logic [9:0] x, y;

  typedef struct packed {
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       line_tick;
    logic       frame_tick;
  } obs_t;

  obs_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   k = 0;
  int   cyc = 0;
  int   last_ft = -1;

  always #5 clk = ~clk;

  vga_controller #(
    .CLK_DIV(DIV), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(POL)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .x(x), .y(y), .video_on(video_on),
    .hsync(hsync), .vsync(vsync), .line_tick(line_tick), .frame_tick(frame_tick)
  );

  // Clock edges seen since the last reset release
  always @(posedge clk or posedge reset) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  function automatic obs_t model(input logic r, input int kk);
    obs_t e;
    int   n, pos, px, py;
    bit   tick;
    e = '0;
    e.hsync = ~POL;
    e.vsync = ~POL;
    if (r || kk == 0) return e;
    n    = kk / DIV;
    tick = (kk % DIV) == 0;
    pos  = n % (HT * VT);
    px   = pos % HT;
    py   = pos / HT;
    e.p_tick     = tick;
    e.x          = 10'(px);
    e.y          = 10'(py);
    e.video_on   = (px < HD) && (py < VD);
    e.hsync      = (px >= HD + HF && px < HD + HF + HS) ? POL : ~POL;
    e.vsync      = (py >= VD + VF && py < VD + VF + VS) ? POL : ~POL;
    e.line_tick  = tick && (px == 0);
    e.frame_tick = tick && (pos == 0);
    return e;
  endfunction

  always @(negedge clk) q.push_back(model(reset, k));

  always @(negedge clk) begin
    obs_t a, e;
    #1;
    cyc++;
    a = {p_tick, x, y, video_on, hsync, vsync, line_tick, frame_tick};
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty t=%0t actual x=%0d y=%0d required a queued expectation", $time, a.x, a.y);
    end else begin
      e = q.pop_front();
      if (a !== e) begin
        fails++;
        $display("FAIL raster t=%0t actual pt=%b x=%0d y=%0d vo=%b hs=%b vs=%b lt=%b ft=%b required pt=%b x=%0d y=%0d vo=%b hs=%b vs=%b lt=%b ft=%b",
                 $time, a.p_tick, a.x, a.y, a.video_on, a.hsync, a.vsync, a.line_tick, a.frame_tick,
                 e.p_tick, e.x, e.y, e.video_on, e.hsync, e.vsync, e.line_tick, e.frame_tick);
      end
    end
    if (reset) begin
      last_ft = -1;
    end else if (frame_tick === 1'b1) begin
      if (last_ft >= 0) begin
        tests++;
        if (cyc - last_ft != FRAME) begin
          fails++;
          $display("FAIL frame_period actual %0d clks required %0d clks", cyc - last_ft, FRAME);
        end
      end
      last_ft = cyc;
    end
  end

  initial begin
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    repeat (FRAME + 500) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(1, 3000)) @(posedge clk);
      #3 reset = 1'b1;
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #3 reset = 1'b0;
    end
    repeat (2 * FRAME + 100) @(posedge clk);
    #20;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
